// File: rtl/enc_rr_arbiter.sv
// Round-robin arbiter granting one requester a whole burst of encoder beats.
// Grant 1 cycle after req; bursts end on the final beat_fire; back-to-back grants have no gap.
module enc_rr_arbiter #(
  parameter int IDX_WIDTH = 4,
  parameter int LEN_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [(1<<IDX_WIDTH)-1:0]            req,
  input  logic [(1<<IDX_WIDTH)*LEN_WIDTH-1:0]  req_len,
  input  logic                                 beat_fire,
  output logic                                 gnt_valid,
  output logic [IDX_WIDTH-1:0]                 gnt_idx,
  output logic [(1<<IDX_WIDTH)-1:0]            gnt_oh,
  output logic                                 gnt_last,
  output logic [LEN_WIDTH-1:0]                 beat_cnt
);

  localparam int N = 1 << IDX_WIDTH;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q;
  logic [IDX_WIDTH-1:0] ptr_q;
  logic [IDX_WIDTH-1:0] gnt_idx_q;
  logic                 gnt_valid_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_cnt_q;

  logic                 any_req;
  logic                 found;
  logic [IDX_WIDTH-1:0] cand;
  logic [IDX_WIDTH-1:0] win_idx;
  logic [LEN_WIDTH-1:0] win_len;
  logic                 at_last;

  // Scan from ptr_q upward; index addition wraps naturally at IDX_WIDTH bits.
  always_comb begin
    found   = 1'b0;
    cand    = '0;
    win_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_q + IDX_WIDTH'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign any_req = |req;
  assign win_len = req_len[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
  assign at_last = (beat_cnt_q == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q     <= GRANT;
            gnt_valid_q <= 1'b1;
            gnt_idx_q   <= win_idx;
            len_q       <= win_len;
            beat_cnt_q  <= '0;
            ptr_q       <= win_idx + IDX_WIDTH'(1);
          end
        end
        GRANT: begin
          if (beat_fire) begin
            if (!at_last) begin
              beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
            end else if (any_req) begin
              gnt_idx_q  <= win_idx;
              len_q      <= win_len;
              beat_cnt_q <= '0;
              ptr_q      <= win_idx + IDX_WIDTH'(1);
            end else begin
              // Return to a clean all-zero output state while idle.
              state_q     <= IDLE;
              gnt_valid_q <= 1'b0;
              gnt_idx_q   <= '0;
              len_q       <= '0;
              beat_cnt_q  <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_oh    = gnt_valid_q ? (N'(1) << gnt_idx_q) : '0;
  assign gnt_last  = gnt_valid_q && at_last;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: doc/enc_rr_arbiter.md
Name: enc_rr_arbiter

Overview:
- Round-robin arbiter that shares one encoder datapath port among N = 2^IDX_WIDTH requesters.
- Grants one requester at a time and holds the grant for a whole burst, counted in accepted beats.
- Drives both a binary grant index and the matching one-hot grant vector, which steers the encoder input mux and bank enables.
- Sits between the per-lane request sources and the encoder core.

Parameters:
- IDX_WIDTH, 4, width of the grant index; number of requesters N = 1 << IDX_WIDTH (localparam).
- LEN_WIDTH, 8, width of each requester's burst-length field; a field value L means a burst of L+1 beats.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request level.
- req_len  input  N*LEN_WIDTH  packed burst lengths; requester i uses bits [i*LEN_WIDTH +: LEN_WIDTH]; sampled only at grant time.
- beat_fire  input  1  encoder accepted one beat from the granted requester this cycle.
- gnt_valid  output  1  a grant is active.
- gnt_idx  output  IDX_WIDTH  index of the granted requester.
- gnt_oh  output  N  one-hot grant; equals (1 << gnt_idx) when gnt_valid=1, all-zero otherwise.
- gnt_last  output  1  combinational; high when gnt_valid=1 and the current beat is the final beat of the burst.
- beat_cnt  output  LEN_WIDTH  beats already accepted in the current burst.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - Priority pointer ptr=0.
  - gnt_valid=0, gnt_idx=0, gnt_oh=0, beat_cnt=0, len_q=0, gnt_last=0.
  - Reset mid-burst aborts the burst immediately; no beat completion is reported.
- Arbitration function (combinational):
  - Scan requesters ptr, ptr+1, … modulo N.
  - The first requester with req set wins.
  - Index arithmetic wraps modulo N; ptr+1 from N-1 gives 0.
- IDLE state:
  - If any req bit is set, on the next edge: state GRANT, gnt_idx=winner, gnt_valid=1, len_q=req_len[winner], beat_cnt=0, ptr=winner+1.
  - Grant latency is 1 cycle from req high to gnt_valid high.
  - If no req bit is set, stay in IDLE.
- GRANT state:
  - beat_fire with beat_cnt != len_q increments beat_cnt.
  - beat_fire with beat_cnt == len_q ends the burst.
  - On burst end, arbitration runs on the same edge using the already-updated ptr.
  - If any req is set, the next grant starts back-to-back: gnt_valid stays 1, new gnt_idx, beat_cnt=0, new len_q, ptr updated.
  - If no req is set, go to IDLE with gnt_valid=0 the next cycle.
  - No beat_fire: hold all state.
- Grant hold rules:
  - Deasserting req[gnt_idx] mid-burst does not revoke the grant; the burst completes.
  - req_len changes after the grant are ignored.
  - The just-finished requester may win again only if no other requester is asserting. Its request is scanned last because ptr = winner+1.
- beat_fire while in IDLE is ignored: no state change, no error.
- len_q = 0 gives a single-beat burst; gnt_last=1 from the first grant cycle.
- len_q = 2^LEN_WIDTH-1 gives the maximum burst of 2^LEN_WIDTH beats; beat_cnt never wraps.
- Fairness: a continuously asserting requester waits at most N-1 bursts before it is granted.
- gnt_oh is produced from gnt_idx through index-to-one-hot decoding, gated by gnt_valid. It is exactly one-hot or zero in every cycle.

Test Plan (IDX_WIDTH=2, N=4, LEN_WIDTH=8):
- Reset then single request: req=4'b0100, req_len[2]=3, beat_fire held 1.
  - One cycle later: gnt_valid=1, gnt_idx=2, gnt_oh=4'b0100.
  - gnt_last high on the 4th beat; gnt_valid=0 the cycle after.
  - ptr=3.
- Round-robin rotation: req=4'b1111, all lengths 0, beat_fire=1 continuous.
  - gnt_idx sequence 0,1,2,3,0 on consecutive cycles, with no gnt_valid gap.
- Wrap and skip: ptr=3 and req=4'b0011.
  - gnt_idx=0, then 1.
  - After that, req=4'b0010 only: gnt_idx=1 again.
- Grant hold:
  - Grant idx 1 with len 5; drop req[1] after the 2nd beat.
  - Grant persists until 6 beats complete.
  - beat_cnt counts 0..5, and gnt_last is high only at beat_cnt=5.
- Stall and IDLE noise:
  - beat_fire=0 for 10 cycles mid-burst: beat_cnt frozen.
  - beat_fire pulses in IDLE with req=0: outputs stay 0.
- Async reset mid-burst: assert rst_n=0 at beat 2 of 8.
  - gnt_valid, gnt_oh and beat_cnt go to 0 without a clock edge.
  - After release with req=4'b1000: grant goes to idx 3 (ptr=0 scan).
